// File: rtl/eth_crc32_d16.sv
// Parallel CRC-32 (poly 0x04C11DB7, MSB-first, no reflection, no final XOR)
// folding one 16-bit word per clock into a 32-bit register.
module eth_crc32_d16 #(
  parameter logic [31:0] POLY = 32'h04C11DB7,
  parameter logic [31:0] INIT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        crc_en,
  output logic [31:0] crc_out
);

  localparam int unsigned CRC_W  = 32;
  localparam int unsigned DATA_W = 16;

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic [CRC_W-1:0] crc_step;

  // Unrolled LFSR: DATA_W serial steps, data_in[15] consumed first
  always_comb begin
    logic fb;
    crc_step = crc_q;
    fb       = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb       = crc_step[CRC_W-1] ^ data_in[i];
      crc_step = {crc_step[CRC_W-2:0], 1'b0} ^ (fb ? POLY : CRC_W'(0));
    end
  end

  // Next-state select: fold the word only when enabled, otherwise hold
  always_comb begin
    crc_d = crc_q;
    if (crc_en) begin
      crc_d = crc_step;
    end
  end

  // CRC register; reset wins over crc_en and discards the presented word
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: tb/tb_eth_crc32_d16.sv
// Randomized self-checking bench for eth_crc32_d16 against a message-level
// reference that recomputes the CRC of the whole accepted word history.
module tb_eth_crc32_d16;

  localparam logic [31:0] POLY     = 32'h04C11DB7;
  localparam logic [31:0] INIT     = 32'hFFFFFFFF;
  localparam int unsigned N_HDR    = 25;
  localparam int unsigned N_PAY    = 52;
  localparam int unsigned N_STREAM = N_HDR + N_PAY;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        crc_en;
  logic [31:0] crc_out;

  int checks   = 0;
  int failures = 0;

  // Every word accepted since the last reset, in order
  logic [15:0] msg[$];
  logic [15:0] stream[N_STREAM];
  logic [31:0] final_gapless;
  logic [31:0] final_gapped;
  logic [31:0] snap;

  eth_crc32_d16 #(.POLY(POLY), .INIT(INIT)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .crc_en  (crc_en),
    .crc_out (crc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // CRC of the full message: INIT, then every bit MSB-first through polynomial division
  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    logic        top;
    c = INIT;
    foreach (msg[i]) begin
      for (int b = 15; b >= 0; b--) begin
        top = c[31] ^ msg[i][b];
        c   = {c[30:0], 1'b0};
        if (top) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  // Apply one cycle of inputs, update the message history, compare after the edge
  task automatic cycle(input logic r, input logic e, input logic [15:0] d);
    rst     = r;
    crc_en  = e;
    data_in = d;
    @(posedge clk);
    #1;
    if (r) msg.delete();
    else if (e) msg.push_back(d);
    chk("model", crc_out, ref_crc());
  endtask

  initial begin
    rst     = 1'b1;
    crc_en  = 1'b0;
    data_in = 16'h0000;

    // Reset and idle hold
    cycle(1'b1, 1'b0, 16'h0000);
    chk("reset", crc_out, 32'hFFFFFFFF);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 16'($urandom));
      chk("idle_hold", crc_out, 32'hFFFFFFFF);
    end

    // All-ones words cancel the INIT preset
    cycle(1'b0, 1'b1, 16'hFFFF);
    chk("ffff_1", crc_out, 32'hFFFF0000);
    cycle(1'b0, 1'b1, 16'hFFFF);
    chk("ffff_2", crc_out, 32'h00000000);

    // Single low bit from zero yields the polynomial; disabled word is ignored
    cycle(1'b0, 1'b1, 16'h0001);
    chk("poly", crc_out, 32'h04C11DB7);
    cycle(1'b0, 1'b0, 16'h0000);
    chk("hold_en0", crc_out, 32'h04C11DB7);

    // Back-to-back header + payload stream, then residue
    cycle(1'b1, 1'b0, 16'h0000);
    foreach (stream[i]) begin
      stream[i] = 16'($urandom);
      cycle(1'b0, 1'b1, stream[i]);
    end
    final_gapless = crc_out;
    snap = crc_out;
    cycle(1'b0, 1'b1, snap[31:16]);
    cycle(1'b0, 1'b1, snap[15:0]);
    chk("residue", crc_out, 32'h00000000);

    // Reset mid-stream discards state and the word presented with it
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'($urandom));
    cycle(1'b1, 1'b1, 16'h1234);
    chk("mid_reset", crc_out, 32'hFFFFFFFF);
    cycle(1'b0, 1'b1, 16'hFFFF);
    chk("restart", crc_out, 32'hFFFF0000);

    // Same stream with random bubbles must give the same CRC
    cycle(1'b1, 1'b0, 16'h0000);
    foreach (stream[i]) begin
      while ($urandom_range(0, 2) == 0) cycle(1'b0, 1'b0, 16'($urandom));
      cycle(1'b0, 1'b1, stream[i]);
    end
    final_gapped = crc_out;
    chk("gapped", final_gapped, final_gapless);
    snap = crc_out;
    cycle(1'b0, 1'b1, snap[31:16]);
    cycle(1'b0, 1'b0, 16'($urandom));
    cycle(1'b0, 1'b1, snap[15:0]);
    chk("gapped_residue", crc_out, 32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
